// File: rtl/mem_bus_reader.sv
// Burst reader for a shared tri-state register bus: selects one register at a
// time, captures its word and holds it until the consumer takes it.
module mem_bus_reader #(
    parameter int NrOfBits = 8,
    parameter int NrOfRegs = 16,
    parameter int AddrBits = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                start,
    input  logic [AddrBits-1:0] base_addr,
    input  logic [AddrBits-1:0] count,
    input  logic [NrOfBits-1:0] bus_in,
    input  logic                rd_ready,
    output logic [NrOfRegs-1:0] cs_n,
    output logic [NrOfBits-1:0] rd_data,
    output logic                rd_valid,
    output logic [AddrBits-1:0] rd_index,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {IDLE, SELECT, CAPTURE, HOLD, DONE} state_t;

    localparam logic [AddrBits:0]   REGS = (AddrBits+1)'(NrOfRegs);
    localparam logic [AddrBits-1:0] LAST = AddrBits'(NrOfRegs - 1);
    localparam logic [AddrBits-1:0] ONE  = AddrBits'(1);

    state_t              state, state_nxt;
    logic [AddrBits-1:0] cur_addr, remaining;
    logic [NrOfRegs-1:0] sel;
    logic                bad_req;

    assign bad_req = ({1'b0, base_addr} >= REGS);
    assign sel     = NrOfRegs'(1) << cur_addr;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_comb begin
        state_nxt = state;
        cs_n      = '1;
        case (state)
            IDLE: begin
                if (start && !bad_req)
                    state_nxt = (count == '0) ? DONE : SELECT;
            end
            SELECT: begin
                cs_n      = ~sel;
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                cs_n      = ~sel;
                state_nxt = HOLD;
            end
            HOLD: begin
                // cs_n released here gives every select a high gap before the next one
                if (rd_ready)
                    state_nxt = (remaining == ONE) ? DONE : SELECT;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            rd_data   <= '0;
            rd_index  <= '0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
        end else if (Tick) begin
            state <= state_nxt;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_req) begin
                            err <= 1'b1;
                        end else begin
                            cur_addr  <= base_addr;
                            remaining <= count;
                        end
                    end
                end
                CAPTURE: begin
                    rd_data  <= bus_in;
                    rd_index <= cur_addr;
                    rd_valid <= 1'b1;
                end
                HOLD: begin
                    if (rd_ready) begin
                        rd_valid  <= 1'b0;
                        remaining <= remaining - ONE;
                        if (remaining != ONE)
                            cur_addr <= (cur_addr == LAST) ? '0 : cur_addr + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_reader.sv
// Directed bench for mem_bus_reader: a 16-register and a 12-register instance
// on modelled buses (reg i holds 0xA0+i and 0x50+i respectively).
module tb_mem_bus_reader;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Tick = 1'b0;
    logic        rd_ready = 1'b1;

    logic        start_a = 1'b0;
    logic [3:0]  base_a = '0, count_a = '0;
    logic [7:0]  bus_a, rd_data_a;
    logic [15:0] cs_n_a;
    logic        rd_valid_a, busy_a, done_a, err_a;
    logic [3:0]  rd_index_a;

    logic        start_b = 1'b0;
    logic [4:0]  base_b = '0, count_b = '0;
    logic [7:0]  bus_b, rd_data_b;
    logic [11:0] cs_n_b;
    logic        rd_valid_b, busy_b, done_b, err_b;
    logic [4:0]  rd_index_b;

    int ntests = 0;
    int nfail  = 0;

    mem_bus_reader #(.NrOfBits(8), .NrOfRegs(16), .AddrBits(4)) dut_a (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .start(start_a),
        .base_addr(base_a), .count(count_a), .bus_in(bus_a), .rd_ready(rd_ready),
        .cs_n(cs_n_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .rd_index(rd_index_a), .busy(busy_a), .done(done_a), .err(err_a));

    mem_bus_reader #(.NrOfBits(8), .NrOfRegs(12), .AddrBits(5)) dut_b (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .start(start_b),
        .base_addr(base_b), .count(count_b), .bus_in(bus_b), .rd_ready(rd_ready),
        .cs_n(cs_n_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .rd_index(rd_index_b), .busy(busy_b), .done(done_b), .err(err_b));

    always #5 Clock = ~Clock;

    always_comb begin
        bus_a = 8'h00;
        for (int i = 0; i < 16; i++)
            if (!cs_n_a[i]) bus_a = 8'hA0 + 8'(i);
    end

    always_comb begin
        bus_b = 8'h00;
        for (int i = 0; i < 12; i++)
            if (!cs_n_b[i]) bus_b = 8'h50 + 8'(i);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [15:0] csa(input int idx);
        return 16'hFFFF ^ (16'h0001 << idx);
    endfunction

    initial begin
        // reset state
        #3;
        chk("rst_cs_n", cs_n_a, 16'hFFFF);
        chk("rst_rd_data", rd_data_a, 0);
        chk("rst_rd_index", rd_index_a, 0);
        chk("rst_rd_valid", rd_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        step();
        Reset = 1'b0;
        Tick = 1'b1;
        step();

        // single word from reg 5
        start_a = 1'b1; base_a = 4'd5; count_a = 4'd1;
        step();
        start_a = 1'b0;
        chk("s1_sel_cs", cs_n_a, 16'hFFDF);
        chk("s1_sel_busy", busy_a, 1);
        step();
        chk("s1_cap_cs", cs_n_a, 16'hFFDF);
        chk("s1_cap_valid", rd_valid_a, 0);
        step();
        chk("s1_hold_cs", cs_n_a, 16'hFFFF);
        chk("s1_hold_valid", rd_valid_a, 1);
        chk("s1_hold_data", rd_data_a, 8'hA5);
        chk("s1_hold_index", rd_index_a, 5);
        step();
        chk("s1_done", done_a, 1);
        chk("s1_done_valid", rd_valid_a, 0);
        chk("s1_done_busy", busy_a, 1);
        step();
        chk("s1_idle_done", done_a, 0);
        chk("s1_idle_busy", busy_a, 0);

        // four words wrapping 14,15,0,1
        start_a = 1'b1; base_a = 4'd14; count_a = 4'd4;
        step();
        start_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("wrap_sel_cs", cs_n_a, csa((14 + k) % 16));
            step();
            chk("wrap_cap_cs", cs_n_a, csa((14 + k) % 16));
            step();
            chk("wrap_data", rd_data_a, 8'hA0 + 8'((14 + k) % 16));
            chk("wrap_index", rd_index_a, (14 + k) % 16);
            chk("wrap_hold_cs", cs_n_a, 16'hFFFF);
            step();
        end
        chk("wrap_done", done_a, 1);
        step();
        chk("wrap_idle", busy_a, 0);

        // consumer stalls 5 Ticks; a start while busy must be ignored
        start_a = 1'b1; base_a = 4'd3; count_a = 4'd2;
        step();
        start_a = 1'b0;
        step();
        rd_ready = 1'b0;
        step();
        chk("stall_data0", rd_data_a, 8'hA3);
        start_a = 1'b1; base_a = 4'd9; count_a = 4'd1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", rd_valid_a, 1);
            chk("stall_data", rd_data_a, 8'hA3);
            chk("stall_cs", cs_n_a, 16'hFFFF);
        end
        rd_ready = 1'b1;
        step();
        chk("stall_sel2_cs", cs_n_a, csa(4));
        step();
        step();
        chk("stall_data2", rd_data_a, 8'hA4);
        chk("stall_index2", rd_index_a, 4);
        step();
        chk("stall_done", done_a, 1);
        start_a = 1'b0;
        step();
        chk("stall_idle_busy", busy_a, 0);
        chk("stall_idle_cs", cs_n_a, 16'hFFFF);

        // Tick toggling: only Tick=1 edges advance
        start_a = 1'b1; base_a = 4'd7; count_a = 4'd1;
        step();
        start_a = 1'b0; Tick = 1'b0;
        step();
        chk("tick_sel_hold_cs", cs_n_a, csa(7));
        Tick = 1'b1; step();
        Tick = 1'b0; step();
        chk("tick_cap_hold_valid", rd_valid_a, 0);
        chk("tick_cap_hold_cs", cs_n_a, csa(7));
        Tick = 1'b1; step();
        chk("tick_hold_data", rd_data_a, 8'hA7);
        Tick = 1'b0; step();
        chk("tick_hold_valid", rd_valid_a, 1);
        Tick = 1'b1; step();
        chk("tick_done", done_a, 1);
        Tick = 1'b0; step();
        chk("tick_done_held", done_a, 1);
        Tick = 1'b1; step();
        chk("tick_idle_done", done_a, 0);
        chk("tick_idle_busy", busy_a, 0);

        // 12-register instance: out-of-range base, wrap, count=0, err priority
        start_b = 1'b1; base_b = 5'd16; count_b = 5'd3;
        step();
        start_b = 1'b0;
        chk("b_err", err_b, 1);
        chk("b_err_busy", busy_b, 0);
        chk("b_err_cs", cs_n_b, 12'hFFF);
        step();
        chk("b_err_clear", err_b, 0);
        start_b = 1'b1; base_b = 5'd11; count_b = 5'd2;
        step();
        start_b = 1'b0;
        chk("b_wrap_cs11", cs_n_b, 12'h7FF);
        step(); step();
        chk("b_wrap_data11", rd_data_b, 8'h5B);
        step();
        chk("b_wrap_cs0", cs_n_b, 12'hFFE);
        step(); step();
        chk("b_wrap_data0", rd_data_b, 8'h50);
        chk("b_wrap_index0", rd_index_b, 0);
        step();
        chk("b_wrap_done", done_b, 1);
        step();
        start_b = 1'b1; base_b = 5'd3; count_b = 5'd0;
        step();
        start_b = 1'b0;
        chk("b_cnt0_done", done_b, 1);
        chk("b_cnt0_cs", cs_n_b, 12'hFFF);
        chk("b_cnt0_err", err_b, 0);
        step();
        chk("b_cnt0_idle", done_b, 0);
        start_b = 1'b1; base_b = 5'd20; count_b = 5'd0;
        step();
        start_b = 1'b0;
        chk("b_prio_err", err_b, 1);
        chk("b_prio_done", done_b, 0);
        step();

        // reset during CAPTURE of a 3-word burst
        start_a = 1'b1; base_a = 4'd2; count_a = 4'd3;
        step();
        start_a = 1'b0;
        step();
        chk("rc_cap_cs", cs_n_a, csa(2));
        Reset = 1'b1;
        #1;
        chk("rc_cs", cs_n_a, 16'hFFFF);
        chk("rc_data", rd_data_a, 0);
        chk("rc_index", rd_index_a, 0);
        chk("rc_busy", busy_a, 0);
        chk("rc_done", done_a, 0);
        step();
        chk("rc_done_later", done_a, 0);
        Reset = 1'b0;
        step();
        chk("rc_after_valid", rd_valid_a, 0);
        start_a = 1'b1; base_a = 4'd0; count_a = 4'd1;
        step();
        start_a = 1'b0;
        chk("rc_fresh_cs", cs_n_a, csa(0));
        step(); step();
        chk("rc_fresh_data", rd_data_a, 8'hA0);
        chk("rc_fresh_index", rd_index_a, 0);
        chk("rc_fresh_valid", rd_valid_a, 1);
        step();
        chk("rc_fresh_done", done_a, 1);
        step();
        chk("rc_fresh_idle", busy_a, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
